// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - request, response and ALU bus for alu_share_ctrl
// Optional rsp_flag present when ALU_FLAGS_EN is defined.
interface alu_share_ctrl_if #(
   parameter int DATA_W = 4
);
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic              req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              alu_en;
   logic              alu_sel;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_c;
`ifdef ALU_FLAGS_EN
   logic              rsp_flag;
`endif

   modport master (
      output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
      output rsp_ready, alu_c,
      input  req_ready, rsp_valid, rsp_id, rsp_data,
      input  alu_en, alu_sel, alu_a, alu_b
`ifdef ALU_FLAGS_EN
      , input rsp_flag
`endif
   );

   modport slave (
      input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
      input  rsp_ready, alu_c,
      output req_ready, rsp_valid, rsp_id, rsp_data,
      output alu_en, alu_sel, alu_a, alu_b
`ifdef ALU_FLAGS_EN
      , output rsp_flag
`endif
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sequencer sharing one add/sub ALU between two requesters
// Define ALU_FLAGS_EN to add rsp_flag (carry for add, borrow for sub).
module alu_share_ctrl #(
   parameter int DATA_W      = 4,
   parameter int EXEC_CYCLES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   alu_share_ctrl_if.slave   io_bus,
   output logic              o_busy
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [3:0] LP_CNT_INIT = 4'(EXEC_CYCLES - 1);

   logic [1:0]        r_state;
   logic              r_rr_ptr;
   logic              r_id;
   logic [3:0]        r_cnt;
   logic              r_alu_en;
   logic              r_alu_sel;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic              r_rsp_valid;
   logic              r_rsp_id;
   logic [DATA_W-1:0] r_rsp_data;

   logic [1:0]        w_ready;
   logic              w_xfer;
   logic              w_gid;
   logic              w_op;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic              w_done;

   always_comb begin
      w_ready = 2'b00;
      if (i_rst_n && r_state == ST_IDLE) begin
         case (io_bus.req_valid)
            2'b01:   w_ready = 2'b01;
            2'b10:   w_ready = 2'b10;
            2'b11:   w_ready = r_rr_ptr ? 2'b10 : 2'b01;
            default: w_ready = 2'b00;
         endcase
      end
   end

   // w_ready is only ever set on a valid bit, so any ready bit is a transfer
   assign w_xfer = |w_ready;
   assign w_gid  = w_ready[1];
   assign w_op   = w_gid ? io_bus.req1_op : io_bus.req0_op;
   assign w_a    = w_gid ? io_bus.req1_a  : io_bus.req0_a;
   assign w_b    = w_gid ? io_bus.req1_b  : io_bus.req0_b;
   assign w_done = (r_state == ST_EXEC) && (r_cnt == 4'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= 1'b0;
         r_id        <= 1'b0;
         r_cnt       <= 4'd0;
         r_alu_en    <= 1'b0;
         r_alu_sel   <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_id      <= w_gid;
                  r_rr_ptr  <= ~w_gid;
                  r_cnt     <= LP_CNT_INIT;
                  r_alu_en  <= 1'b1;
                  r_alu_sel <= w_op;
                  r_alu_a   <= w_a;
                  r_alu_b   <= w_b;
                  r_state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_done) begin
                  r_rsp_data  <= io_bus.alu_c;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_alu_en    <= 1'b0;
                  r_alu_sel   <= 1'b0;
                  r_alu_a     <= '0;
                  r_alu_b     <= '0;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (io_bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_FLAGS_EN
   logic              r_rsp_flag;
   logic [DATA_W:0]   w_sum;
   logic              w_flag;

   // the ALU registers still hold the operands on the capture edge
   assign w_sum  = {1'b0, r_alu_a} + {1'b0, r_alu_b};
   assign w_flag = r_alu_sel ? (r_alu_a < r_alu_b) : w_sum[DATA_W];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_flag <= 1'b0;
      end else if (w_done) begin
         r_rsp_flag <= w_flag;
      end
   end

   assign io_bus.rsp_flag = r_rsp_flag;
`endif

   assign io_bus.req_ready = w_ready;
   assign io_bus.rsp_valid = r_rsp_valid;
   assign io_bus.rsp_id    = r_rsp_id;
   assign io_bus.rsp_data  = r_rsp_data;
   assign io_bus.alu_en    = r_alu_en;
   assign io_bus.alu_sel   = r_alu_sel;
   assign io_bus.alu_a     = r_alu_a;
   assign io_bus.alu_b     = r_alu_b;
   assign o_busy           = (r_state != ST_IDLE);
endmodule
